// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, state and response types for the ALU command sequencer.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CMD_W       = 4;
  localparam int unsigned TMR_W       = 8;
  localparam int unsigned ALU_OP_LAST = 8;

  typedef enum logic [CMD_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_SLT  = 4'd3,
    OP_AND  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_OR   = 4'd7,
    OP_SHFT = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carryout;
    logic              zero;
    logic              overflow;
    logic              error;
  } rsp_t;

  function automatic logic is_legal_op(input logic [CMD_W-1:0] cmd);
    return cmd <= CMD_W'(ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response valid-ready bus between a requester (master) and the sequencer (slave).
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [CMD_W-1:0]  req_command;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carryout;
  logic              rsp_zero;
  logic              rsp_overflow;
  logic              rsp_error;

  modport master (
    output req_valid, req_command, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_error
  );

  modport slave (
    input  req_valid, req_command, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_error
  );

endinterface

// File: rtl/alu_sequencer_settle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module alu_sequencer_settle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: drives held operands, waits SETTLE cycles,
// then returns the registered result with locally derived flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned WIDTH  = DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  alu_sequencer_if.slave    io_seq,
  output logic [CMD_W-1:0]  o_alu_command,
  output logic [WIDTH-1:0]  o_alu_a,
  output logic [WIDTH-1:0]  o_alu_b,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic              i_alu_carryout
);

  state_e             r_state, w_state_nxt;
  opcode_e            r_op, w_op_nxt;
  logic [CMD_W-1:0]   r_alu_cmd, w_alu_cmd_nxt;
  logic [WIDTH-1:0]   r_alu_a, w_alu_a_nxt;
  logic [WIDTH-1:0]   r_alu_b, w_alu_b_nxt;
  logic               r_err_pend, w_err_pend_nxt;
  logic               r_req_ready;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  rsp_t               r_rsp, w_rsp_nxt, w_cap;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_en;
  logic               w_tmr_done_c;
  logic               w_add_ovf;
  logic               w_sub_ovf;

  alu_sequencer_settle_timer #(.W(TMR_W)) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done_c   (w_tmr_done_c)
  );

  // Signed overflow for the adder, judged against the operands actually driven
  assign w_add_ovf = (r_alu_a[WIDTH-1] == r_alu_b[WIDTH-1]) && (i_alu_result[WIDTH-1] != r_alu_a[WIDTH-1]);
  assign w_sub_ovf = (r_alu_a[WIDTH-1] != r_alu_b[WIDTH-1]) && (i_alu_result[WIDTH-1] != r_alu_a[WIDTH-1]);

  always_comb begin
    w_cap          = '0;
    w_cap.result   = i_alu_result;
    unique case (r_op)
      OP_ADD: begin
        w_cap.carryout = i_alu_carryout;
        w_cap.overflow = w_add_ovf;
      end
      OP_SUB: begin
        w_cap.carryout = i_alu_carryout;
        w_cap.overflow = w_sub_ovf;
      end
      OP_SLT: begin
        w_cap.result = DATA_W'(i_alu_result[WIDTH-1] ^ w_sub_ovf);
      end
      default: ;
    endcase
    w_cap.zero = (w_cap.result == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_alu_cmd_nxt   = r_alu_cmd;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_err_pend_nxt  = r_err_pend;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_nxt       = r_rsp;
    w_tmr_load      = 1'b0;
    w_tmr_val       = '0;
    w_tmr_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_seq.req_valid) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = ST_WAIT;
          if (is_legal_op(io_seq.req_command)) begin
            w_tmr_val      = TMR_W'(SETTLE - 1);
            w_op_nxt       = opcode_e'(io_seq.req_command);
            w_alu_cmd_nxt  = (opcode_e'(io_seq.req_command) == OP_SLT) ? CMD_W'(OP_SUB) : io_seq.req_command;
            w_alu_a_nxt    = io_seq.req_a;
            w_alu_b_nxt    = io_seq.req_b;
            w_err_pend_nxt = 1'b0;
          end else begin
            // Illegal ops pass through one zero-length wait so the response lands one cycle later
            w_err_pend_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (w_tmr_done_c) begin
          if (r_err_pend) begin
            w_rsp_nxt       = '0;
            w_rsp_nxt.error = 1'b1;
          end else begin
            w_rsp_nxt = w_cap;
          end
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && io_seq.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op        <= OP_ADD;
      r_alu_cmd   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_err_pend  <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      r_op        <= w_op_nxt;
      r_alu_cmd   <= w_alu_cmd_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_err_pend  <= w_err_pend_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp       <= w_rsp_nxt;
    end
  end

  assign o_alu_command       = r_alu_cmd;
  assign o_alu_a             = r_alu_a;
  assign o_alu_b             = r_alu_b;
  assign io_seq.req_ready    = r_req_ready;
  assign io_seq.rsp_valid    = r_rsp_valid;
  assign io_seq.rsp_result   = r_rsp.result;
  assign io_seq.rsp_carryout = r_rsp.carryout;
  assign io_seq.rsp_zero     = r_rsp.zero;
  assign io_seq.rsp_overflow = r_rsp.overflow;
  assign io_seq.rsp_error    = r_rsp.error;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: stimulus pushes expected responses, a monitor pops and checks.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int unsigned SETTLE = 4;

  typedef struct {
    rsp_t  rsp;
    int    acc;
    int    lat;
    string name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  alu_command;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [32:0] alu_sum;
  logic        alu_carryout;
  logic [3:0]  last_cmd;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  alu_sequencer_if bus_if ();

  alu_sequencer #(.SETTLE(SETTLE), .WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .io_seq         (bus_if),
    .o_alu_command  (alu_command),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .i_alu_result   (alu_result),
    .i_alu_carryout (alu_carryout)
  );

  // Behavioural ALU; SUB carry is the no-borrow carry of a + ~b + 1
  always_comb begin
    alu_sum      = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    case (alu_command)
      4'd0: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_sum[31:0];
        alu_carryout = alu_sum[32];
      end
      4'd1: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result   = alu_sum[31:0];
        alu_carryout = alu_sum[32];
      end
      4'd2: alu_result = alu_a ^ alu_b;
      4'd4: alu_result = alu_a & alu_b;
      4'd5: alu_result = ~(alu_a & alu_b);
      4'd6: alu_result = ~(alu_a | alu_b);
      4'd7: alu_result = alu_a | alu_b;
      4'd8: alu_result = alu_a << alu_b[4:0];
      default: alu_result = '0;
    endcase
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic c, input logic z, input logic o, input logic e);
    exp_t x;
    int   n;
    @(negedge clk);
    bus_if.req_valid   = 1'b1;
    bus_if.req_command = cmd;
    bus_if.req_a       = a;
    bus_if.req_b       = b;
    n = 0;
    while (!bus_if.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.req_ready) begin
      chk({nm, " accept timeout"}, 64'(bus_if.req_ready), 64'(1));
      bus_if.req_valid = 1'b0;
      return;
    end
    x.rsp.result   = res;
    x.rsp.carryout = c;
    x.rsp.zero     = z;
    x.rsp.overflow = o;
    x.rsp.error    = e;
    x.acc          = cyc + 1;
    x.lat          = e ? 1 : int'(SETTLE);
    x.name         = nm;
    sb.push_back(x);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    if (!e) last_cmd = (cmd == 4'd3) ? 4'd1 : cmd;
    chk({nm, " alu_command"}, 64'(alu_command), 64'(last_cmd));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus_if.rsp_valid || !bus_if.req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " drain pending"}, 64'(sb.size()), 64'(0));
  endtask

  // Monitor: pop on rsp_valid rise, then re-check the held response every cycle it stays valid
  initial begin
    exp_t cur;
    logic have;
    logic prev_v;
    have   = 1'b0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have   = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (bus_if.rsp_valid && !prev_v) begin
          if (sb.size() == 0) begin
            chk("unexpected rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
            have = 1'b0;
          end else begin
            cur  = sb.pop_front();
            have = 1'b1;
            chk({cur.name, " latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
          end
        end
        if (bus_if.rsp_valid && have) begin
          chk({cur.name, " rsp"}, 64'({bus_if.rsp_result, bus_if.rsp_carryout, bus_if.rsp_zero,
                                      bus_if.rsp_overflow, bus_if.rsp_error}), 64'(cur.rsp));
          chk({cur.name, " req_ready in RESP"}, 64'(bus_if.req_ready), 64'(0));
        end
        prev_v = bus_if.rsp_valid;
      end
    end
  end

  initial begin
    int n;
    bus_if.req_valid   = 1'b0;
    bus_if.req_command = '0;
    bus_if.req_a       = '0;
    bus_if.req_b       = '0;
    bus_if.rsp_ready   = 1'b1;
    last_cmd           = 4'd0;
    rst                = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 64'(bus_if.req_ready), 64'(1));
    chk("reset rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
    chk("reset alu_command", 64'(alu_command), 64'(0));
    chk("reset alu_a", 64'(alu_a), 64'(0));
    chk("reset rsp_result", 64'(bus_if.rsp_result), 64'(0));
    rst = 1'b0;

    issue("add_5_7",   4'd0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 1'b0);
    issue("slt_neg",   4'd3, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, 1'b0);
    issue("slt_pos",   4'd3, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1, 1'b0, 1'b0);
    issue("slt_ovf",   4'd3, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, 1'b0);
    issue("add_ovf",   4'd0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0, 1'b1, 1'b0);
    issue("add_carry", 4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0, 1'b0);
    issue("sub_5_3",   4'd1, 32'd5,          32'd3,          32'd2,          1'b1, 1'b0, 1'b0, 1'b0);
    issue("sub_ovf",   4'd1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b0, 1'b1, 1'b0);
    issue("xor",       4'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00,  1'b0, 1'b0, 1'b0, 1'b0);
    issue("illegal12", 4'd12, 32'd3,         32'd4,          32'd0,          1'b0, 1'b0, 1'b0, 1'b1);
    issue("and",       4'd4, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0, 1'b0, 1'b0, 1'b0);
    issue("or_zero",   4'd7, 32'd0,          32'd0,          32'd0,          1'b0, 1'b1, 1'b0, 1'b0);
    issue("illegal15", 4'd15, 32'd1,         32'd1,          32'd0,          1'b0, 1'b0, 1'b0, 1'b1);
    drain("directed");

    // Backpressure: response held for 10 cycles while a second request waits
    bus_if.rsp_ready = 1'b0;
    issue("bp_add", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      issue("bp_nor", 4'd6, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        n = 0;
        while (!bus_if.rsp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp rsp_valid seen", 64'(bus_if.rsp_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp req_ready held low", 64'(bus_if.req_ready), 64'(0));
        end
        bus_if.rsp_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset mid-WAIT discards the op and restores power-up outputs
    issue("rst_wait_add", 4'd0, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_wait rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
    chk("rst_wait req_ready", 64'(bus_if.req_ready), 64'(1));
    chk("rst_wait alu_command", 64'(alu_command), 64'(0));
    chk("rst_wait alu_a", 64'(alu_a), 64'(0));
    sb.delete();
    last_cmd = 4'd0;
    @(negedge clk);
    #1 rst = 1'b0;
    issue("nand_ones", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("after_rst_wait");

    // Reset mid-RESP drops rsp_valid asynchronously
    bus_if.rsp_ready = 1'b0;
    issue("rst_resp_xor", 4'd2, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!bus_if.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_resp rsp_valid before", 64'(bus_if.rsp_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("rst_resp rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
    chk("rst_resp rsp_zero", 64'(bus_if.rsp_zero), 64'(0));
    chk("rst_resp req_ready", 64'(bus_if.req_ready), 64'(1));
    sb.delete();
    last_cmd = 4'd0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    issue("shft", 4'd8, 32'd1, 32'd4, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
